// File: rtl/beta_imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter.
//   ARB_FSM_BSIZE : width of the arbiter FSM state encoding
//   arb_fsm_e     : ARB_IDLE (no transaction), ARB_WRDY (waiting for imem
//                   accept), ARB_WVLD (waiting for imem data)
package beta_imem_arb_pkg;

    localparam int ARB_FSM_BSIZE = 2;

    typedef enum logic [ARB_FSM_BSIZE-1:0] {
        ARB_IDLE = 2'd0,
        ARB_WRDY = 2'd1,
        ARB_WVLD = 2'd2
    } arb_fsm_e;

endpackage

// File: rtl/beta_rr_picker.sv
// Combinational round-robin picker.
//   req_i        : request vector, one bit per requester
//   last_grant_i : index granted last; search starts one above it and wraps
//   winner_o     : index of the first requester found (0 when none)
//   any_o        : at least one request is pending
module beta_rr_picker #(
    parameter  int NumReq = 2,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_grant_i,
    output logic [IdxW-1:0]   winner_o,
    output logic              any_o
);

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        // Offsets 1..NumReq visit every index once, ending on last_grant
        // itself so a lone repeat requester is still served.
        for (int off = 1; off <= NumReq; off++) begin
            if (!any_o && req_i[(int'(last_grant_i) + off) % NumReq]) begin
                any_o    = 1'b1;
                winner_o = IdxW'((int'(last_grant_i) + off) % NumReq);
            end
        end
    end

endmodule

// File: rtl/beta_imem_arbiter.sv
// Shares one instruction-memory port between NumReq requesters using
// round-robin arbitration, one outstanding transaction at a time.
//   clk_i, rstn_i          : clock, synchronous active-low reset
//   req_i / req_addr_i     : per-requester request and packed address
//   req_flush_i            : drop the pending response of that requester
//   req_ready_o            : request accepted by memory (1-cycle pulse)
//   req_rvalid_o           : response valid (1-cycle pulse, grantee only)
//   req_rdata_o            : response data, broadcast
//   mem_req_o / mem_addr_o : request towards imem
//   mem_ready_i            : imem accepted the request
//   mem_valid_i/mem_rdata_i: imem response (valid exactly one cycle)
//   arb_busy_o             : a transaction is in flight
//   arb_grant_o            : current/last granted requester
module beta_imem_arbiter
    import beta_imem_arb_pkg::*;
#(
    parameter  int DataWidth = 32,
    parameter  int AddrWidth = 32,
    parameter  int NumReq    = 2,
    localparam int IdxW      = $clog2(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [NumReq-1:0]           req_i,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    input  logic [NumReq-1:0]           req_flush_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic [NumReq-1:0]           req_rvalid_o,
    output logic [DataWidth-1:0]        req_rdata_o,
    output logic                        mem_req_o,
    output logic [AddrWidth-1:0]        mem_addr_o,
    input  logic                        mem_ready_i,
    input  logic                        mem_valid_i,
    input  logic [DataWidth-1:0]        mem_rdata_i,
    output logic                        arb_busy_o,
    output logic [IdxW-1:0]             arb_grant_o
);

    arb_fsm_e             state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic [IdxW-1:0]      last_grant_q, last_grant_d;
    logic                 flush_pend_q, flush_pend_d;

    logic [IdxW-1:0]      pick_idx;
    logic                 pick_any;

    beta_rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .req_i        (req_i),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_idx),
        .any_o        (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        addr_d       = addr_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        flush_pend_d = flush_pend_q;
        req_ready_o  = '0;
        req_rvalid_o = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d      = pick_idx;
                    addr_d       = req_addr_i[pick_idx*AddrWidth +: AddrWidth];
                    mem_req_d    = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = ARB_WRDY;
                end
            end
            ARB_WRDY: begin
                if (req_flush_i[grant_q]) flush_pend_d = 1'b1;
                if (mem_ready_i) begin
                    req_ready_o[grant_q] = 1'b1;
                    mem_req_d            = 1'b0;
                    state_d              = ARB_WVLD;
                end
            end
            ARB_WVLD: begin
                if (req_flush_i[grant_q]) flush_pend_d = 1'b1;
                if (mem_valid_i) begin
                    // A flush arriving in the same cycle as the data still
                    // suppresses it; the memory response is consumed either way.
                    req_rvalid_o[grant_q] = ~(flush_pend_q | req_flush_i[grant_q]);
                    last_grant_d          = grant_q;
                    state_d               = ARB_IDLE;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ARB_IDLE;
            mem_req_q    <= 1'b0;
            addr_q       <= '0;
            grant_q      <= '0;
            last_grant_q <= IdxW'(NumReq - 1);
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            addr_q       <= addr_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = addr_q;
    assign arb_busy_o  = (state_q != ARB_IDLE);
    assign arb_grant_o = grant_q;
    assign req_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_beta_imem_arbiter.sv
// Directed bench for beta_imem_arbiter with a response scoreboard.
module tb_beta_imem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 2;

    logic           clk;
    logic           rstn_i;
    logic [NR-1:0]  req_i;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR-1:0]  req_flush_i;
    logic [NR-1:0]  req_ready_o;
    logic [NR-1:0]  req_rvalid_o;
    logic [DW-1:0]  req_rdata_o;
    logic           mem_req_o;
    logic [AW-1:0]  mem_addr_o;
    logic           mem_ready_i;
    logic           mem_valid_i;
    logic [DW-1:0]  mem_rdata_i;
    logic           arb_busy_o;
    logic           arb_grant_o;

    beta_imem_arbiter #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .NumReq    (NR)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .req_addr_i   (req_addr_i),
        .req_flush_i  (req_flush_i),
        .req_ready_o  (req_ready_o),
        .req_rvalid_o (req_rvalid_o),
        .req_rdata_o  (req_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_valid_i  (mem_valid_i),
        .mem_rdata_i  (mem_rdata_i),
        .arb_busy_o   (arb_busy_o),
        .arb_grant_o  (arb_grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   rv_seen  = 0;

    localparam logic [31:0] ADDR0 = 32'h0000_0100;
    localparam logic [31:0] ADDR1 = 32'h0000_2A40;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Response monitor: every rvalid must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        #2;
        check("ready_onehot0", 32'($onehot0(req_ready_o)), 32'd1);
        if (req_rvalid_o != '0) begin
            rv_seen++;
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 32'(req_rvalid_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rvalid_route", 32'(req_rvalid_o), 32'd1 << e.idx);
                check("rvalid_data", req_rdata_o, e.data);
            end
        end
    end

    // One full transaction starting from ARB_IDLE at a falling edge with req_i
    // already driven. w_r / w_v: extra cycles before ready / valid. extra is
    // OR-ed into req_i once granted; fmask is pulsed on req_flush_i in the
    // first data-wait cycle (needs w_v >= 1); drop releases the grantee's req.
    task automatic txn(input string tag, input int g, input logic [31:0] a,
                       input int w_r, input int w_v, input logic [31:0] d,
                       input logic [1:0] extra, input logic [1:0] fmask, input bit drop);
        exp_t e;
        int   seen0;
        bit   flushed;
        flushed = fmask[g];
        if (!flushed) begin
            e.idx  = g;
            e.data = d;
            sb.push_back(e);
        end
        cyc();
        req_i = req_i | extra;
        #1;
        check({tag, "_memreq"}, 32'(mem_req_o), 32'd1);
        check({tag, "_addr"},   mem_addr_o, a);
        check({tag, "_grant"},  32'(arb_grant_o), 32'(g));
        check({tag, "_busy"},   32'(arb_busy_o), 32'd1);
        for (int i = 0; i < w_r; i++) begin
            check({tag, "_noready"}, 32'(req_ready_o), 32'd0);
            cyc();
            #1;
            check({tag, "_memreq_hold"}, 32'(mem_req_o), 32'd1);
            check({tag, "_addr_hold"},   mem_addr_o, a);
        end
        mem_ready_i = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready_o), 32'd1 << g);
        if (drop) req_i[g] = 1'b0;
        cyc();
        mem_ready_i = 1'b0;
        #1;
        check({tag, "_memreq_low"}, 32'(mem_req_o), 32'd0);
        check({tag, "_busy_wvld"},  32'(arb_busy_o), 32'd1);
        for (int i = 0; i < w_v; i++) begin
            req_flush_i = (i == 0) ? fmask : 2'b00;
            #1;
            check({tag, "_norvalid"}, 32'(req_rvalid_o), 32'd0);
            cyc();
        end
        req_flush_i = 2'b00;
        seen0       = rv_seen;
        mem_valid_i = 1'b1;
        mem_rdata_i = d;
        #3;
        check({tag, "_rv_count"}, 32'(rv_seen - seen0), flushed ? 32'd0 : 32'd1);
        if (flushed) check({tag, "_rv_flushed"}, 32'(req_rvalid_o), 32'd0);
        cyc();
        mem_valid_i = 1'b0;
        mem_rdata_i = $urandom;
        #1;
        check({tag, "_idle_busy"},  32'(arb_busy_o), 32'd0);
        check({tag, "_idle_grant"}, 32'(arb_grant_o), 32'(g));
    endtask

    initial begin
        int seen0;
        rstn_i      = 1'b0;
        req_i       = '0;
        req_addr_i  = {ADDR1, ADDR0};
        req_flush_i = '0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_rdata_i = 32'hDEAD_BEEF;

        // Reset state
        cyc();
        cyc();
        #1;
        check("rst_memreq", 32'(mem_req_o), 32'd0);
        check("rst_addr",   mem_addr_o, 32'd0);
        check("rst_grant",  32'(arb_grant_o), 32'd0);
        check("rst_busy",   32'(arb_busy_o), 32'd0);
        check("rst_ready",  32'(req_ready_o), 32'd0);
        check("rst_rvalid", 32'(req_rvalid_o), 32'd0);
        rstn_i = 1'b1;
        cyc();

        // Spurious memory handshakes while idle
        mem_ready_i = 1'b1;
        mem_valid_i = 1'b1;
        #1;
        check("spur_ready",  32'(req_ready_o), 32'd0);
        check("spur_rvalid", 32'(req_rvalid_o), 32'd0);
        cyc();
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        check("spur_busy",   32'(arb_busy_o), 32'd0);
        check("spur_memreq", 32'(mem_req_o), 32'd0);
        check("spur_grant",  32'(arb_grant_o), 32'd0);
        cyc();

        // Single master, 1-cycle memory
        req_i = 2'b01;
        txn("single", 0, ADDR0, 0, 0, 32'h0050_0093, 2'b00, 2'b00, 1'b1);

        // Flush of the grantee while waiting for data, then a normal request
        req_i = 2'b01;
        txn("flush", 0, ADDR0, 0, 1, 32'h1111_2222, 2'b00, 2'b01, 1'b1);
        req_i = 2'b10;
        txn("post_flush", 1, ADDR1, 0, 0, 32'h3333_4444, 2'b00, 2'b00, 1'b1);

        // Contention after reset: 0,1,0,1; a flush on the idle requester is ignored
        rstn_i = 1'b0;
        cyc();
        cyc();
        rstn_i = 1'b1;
        req_i  = 2'b11;
        txn("cont0", 0, ADDR0, 0, 1, 32'hA000_0000, 2'b00, 2'b10, 1'b0);
        txn("cont1", 1, ADDR1, 0, 0, 32'hA000_0001, 2'b00, 2'b00, 1'b0);
        txn("cont2", 0, ADDR0, 1, 0, 32'hA000_0002, 2'b00, 2'b00, 1'b0);
        txn("cont3", 1, ADDR1, 0, 2, 32'hA000_0003, 2'b00, 2'b00, 1'b0);
        req_i = 2'b00;
        cyc();

        // Slow memory, requester 1 arrives during the transaction
        req_i = 2'b01;
        txn("slow0", 0, ADDR0, 3, 5, 32'hBEEF_0000, 2'b10, 2'b00, 1'b1);
        txn("slow1", 1, ADDR1, 0, 0, 32'hBEEF_0001, 2'b00, 2'b00, 1'b1);
        cyc();

        // Reset while waiting for data; stale valid after release
        req_i = 2'b01;
        cyc();
        mem_ready_i = 1'b1;
        cyc();
        mem_ready_i = 1'b0;
        req_i       = 2'b00;
        #1;
        check("rstmid_busy_wvld", 32'(arb_busy_o), 32'd1);
        rstn_i = 1'b0;
        cyc();
        #1;
        check("rstmid_busy",   32'(arb_busy_o), 32'd0);
        check("rstmid_memreq", 32'(mem_req_o), 32'd0);
        rstn_i = 1'b1;
        cyc();
        seen0       = rv_seen;
        mem_valid_i = 1'b1;
        mem_rdata_i = 32'hBAD0_BAD0;
        #3;
        check("stale_rvalid", 32'(req_rvalid_o), 32'd0);
        check("stale_count",  32'(rv_seen - seen0), 32'd0);
        cyc();
        mem_valid_i = 1'b0;
        #1;
        check("stale_busy",   32'(arb_busy_o), 32'd0);
        check("stale_memreq", 32'(mem_req_o), 32'd0);
        req_i = 2'b11;
        txn("post_rst", 0, ADDR0, 0, 0, 32'hC0DE_0001, 2'b00, 2'b00, 1'b1);
        req_i = 2'b00;
        cyc();
        cyc();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
